// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two write-back
// requesters, with a single registered output stage that freezes while wr_hold=1.
module regfile_wr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DROP_R0 = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              wr_hold,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              grant_id,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // state | meaning
  // LAST0 | req0 owned the last transfer; req1 wins the next conflict
  // LAST1 | req1 owned the last transfer; req0 wins the next conflict (reset)
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } rr_state_t;

  rr_state_t rr_q, rr_d;
  logic      out_valid;
  logic      stage_free;
  logic      xfer0, xfer1;
  logic      drop_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= LAST1;
    else      rr_q <= rr_d;
  end

  always_comb begin
    stage_free = ~out_valid | ~wr_hold;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rr_d       = rr_q;
    if (stage_free) begin
      if (req0_valid && req1_valid) begin
        if (rr_q == LAST0) req1_ready = 1'b1;
        else               req0_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
    xfer0 = req0_valid & req0_ready;
    xfer1 = req1_valid & req1_ready;
    if (xfer0)      rr_d = LAST0;
    else if (xfer1) rr_d = LAST1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      A3        <= '0;
      WD3       <= '0;
      grant_id  <= 1'b0;
    end else if (stage_free) begin
      if (xfer0) begin
        out_valid <= 1'b1;
        A3        <= req0_addr;
        WD3       <= req0_data;
        grant_id  <= 1'b0;
      end else if (xfer1) begin
        out_valid <= 1'b1;
        A3        <= req1_addr;
        WD3       <= req1_data;
        grant_id  <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Entries to r0 still retire through the handshake; only the strobe is masked.
  assign drop_hit = (DROP_R0 != 0) && (A3 == '0);
  assign WE3      = out_valid & ~wr_hold & ~drop_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: table-driven cycles with a write scoreboard, plus
// hand sequences for same-address ordering and reset during an occupied stage.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, wr_hold = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;

  logic        req0_ready, req1_ready, WE3, grant_id;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [7:0]  conflict_cnt;

  logic        nd_r0_ready, nd_r1_ready, nd_we, nd_gid;
  logic [4:0]  nd_a3;
  logic [31:0] nd_wd3;
  logic [7:0]  nd_cnt;

  logic        c2_r0_ready, c2_r1_ready, c2_we, c2_gid;
  logic [4:0]  c2_a3;
  logic [31:0] c2_wd3;
  logic [1:0]  c2_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_hold(wr_hold), .WE3(WE3), .A3(A3), .WD3(WD3), .grant_id(grant_id), .conflict_cnt(conflict_cnt)
  );

  regfile_wr_arbiter #(.DROP_R0(0)) dut_nd (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(nd_r0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(nd_r1_ready),
    .wr_hold(wr_hold), .WE3(nd_we), .A3(nd_a3), .WD3(nd_wd3), .grant_id(nd_gid), .conflict_cnt(nd_cnt)
  );

  regfile_wr_arbiter #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(c2_r0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(c2_r1_ready),
    .wr_hold(wr_hold), .WE3(c2_we), .A3(c2_a3), .WD3(c2_wd3), .grant_id(c2_gid), .conflict_cnt(c2_cnt)
  );

  typedef struct {
    logic        pre_rst;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        hold;
    logic        er0;
    logic        er1;
    logic        ewe;
    logic        ewe_nd;
    int          ecnt;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        id;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] reg7 = '0;

  function automatic vec_t mk(input logic pr, input logic v0, input logic [4:0] a0,
                              input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                              input logic [31:0] d1, input logic hold, input logic er0,
                              input logic er1, input logic ewe, input logic ewe_nd, input int ecnt);
    vec_t v;
    v.pre_rst = pr; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.hold = hold; v.er0 = er0; v.er1 = er1; v.ewe = ewe; v.ewe_nd = ewe_nd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic hold);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    wr_hold = hold;
  endtask

  // Entered and left at posedge+1.
  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_we3", 64'(WE3), 64'd0);
    chk("rst_a3", 64'(A3), 64'd0);
    chk("rst_wd3", 64'(WD3), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
    chk("sb_leftover", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    int   c2_exp;
    drive(v.v0, v.a0, v.d0, v.v1, v.a1, v.d1, v.hold);
    if (v.er0 && v.a0 != 5'd0) begin e.a = v.a0; e.d = v.d0; e.id = 1'b0; sb.push_back(e); end
    if (v.er1 && v.a1 != 5'd0) begin e.a = v.a1; e.d = v.d1; e.id = 1'b1; sb.push_back(e); end
    @(negedge clk);
    chk("req0_ready", 64'(req0_ready), 64'(v.er0));
    chk("req1_ready", 64'(req1_ready), 64'(v.er1));
    chk("we3", 64'(WE3), 64'(v.ewe));
    chk("we3_nodrop", 64'(nd_we), 64'(v.ewe_nd));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(v.ecnt));
    c2_exp = (v.ecnt > 3) ? 3 : v.ecnt;
    chk("conflict_cnt_sat", 64'(c2_cnt), 64'(c2_exp));
    if (WE3 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty_on_write", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk("wr_a3", 64'(A3), 64'(e.a));
        chk("wr_wd3", 64'(WD3), 64'(e.d));
        chk("wr_grant_id", 64'(grant_id), 64'(e.id));
      end
      if (A3 == 5'd7) reg7 = WD3;
    end else if (v.hold && sb.size() > 0) begin
      chk("hold_a3_stable", 64'(A3), 64'(sb[0].a));
      chk("hold_wd3_stable", 64'(WD3), 64'(sb[0].d));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // pr v0 a0 d0 v1 a1 d1 hold | er0 er1 we we_nd cnt
    vecs.push_back(mk(1, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    // round robin after reset: req0 first
    vecs.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h13, 1, 2, 32'h22, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 32'h13, 1, 2, 32'h24, 0, 1, 0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 1, 32'h15, 1, 2, 32'h24, 0, 0, 1, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4));
    // hold with stage full
    vecs.push_back(mk(0, 1, 3, 32'h33, 0, 0, 0, 0, 1, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 4, 32'h44, 1, 6, 32'h66, 1, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 4, 32'h44, 1, 6, 32'h66, 1, 0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 4, 32'h44, 1, 6, 32'h66, 1, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 4, 32'h44, 1, 6, 32'h66, 0, 0, 1, 1, 1, 7));
    vecs.push_back(mk(0, 1, 4, 32'h44, 0, 0, 0, 0, 1, 0, 1, 1, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8));
    // write to r0: consumed, strobe only on the non-dropping instance
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8));
    // same address from both requesters
    vecs.push_back(mk(1, 1, 7, 32'h11, 1, 7, 32'h22, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 32'h22, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) do_reset();
      step(vecs[i]);
    end
    chk("reg7_final", 64'(reg7), 64'h22);

    // reset while the stage holds a write that is being presented
    do_reset();
    drive(1, 9, 32'h99, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_req0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    drive(1, 10, 32'h1010, 1, 11, 32'h1111, 1);
    @(negedge clk);
    chk("t6_hold_we3", 64'(WE3), 64'd0);
    chk("t6_hold_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("t6_hold_a3", 64'(A3), 64'd9);
    chk("t6_hold_wd3", 64'(WD3), 64'h99);
    @(posedge clk); #1;
    wr_hold = 1'b0;
    @(negedge clk);
    chk("t6_pre_we3", 64'(WE3), 64'd1);
    chk("t6_pre_a3", 64'(A3), 64'd9);
    chk("t6_pre_cnt", 64'(conflict_cnt), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_we3", 64'(WE3), 64'd0);
    chk("t6_async_a3", 64'(A3), 64'd0);
    chk("t6_async_wd3", 64'(WD3), 64'd0);
    chk("t6_async_cnt", 64'(conflict_cnt), 64'd0);
    chk("t6_async_cnt_sat", 64'(c2_cnt), 64'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
